// File: rtl/slave_pkg.sv
// -----------------------------------------------------------------------------
// slave_pkg: shared definitions for the serial slave port.
//   - FSM state encoding (state_t)
//   - default address widths and the fixed data width (8 bits)
//   - cnt_width(): width of the shared bit counter, which has to count both the
//     address bits and the 8 transmitted data bits
// -----------------------------------------------------------------------------
package slave_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_MEM_AW = 8;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_WRITE,
        ST_READ_WAIT,
        ST_READ_ACK,
        ST_READ_TX
    } state_t;

    // The counter must reach max(addr_w, DATA_W) - 1.
    function automatic int cnt_width(input int addr_w);
        int n;
        n = (addr_w > DATA_W) ? addr_w : DATA_W;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/slave_bram.sv
// -----------------------------------------------------------------------------
// slave_bram: single-port-style byte memory, 2^AW x 8.
//   Synchronous write, registered (one-cycle) read. Contents are not reset.
// Ports:
//   clock  in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (sampled every cycle)
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module slave_bram
    import slave_pkg::*;
#(
    parameter int AW = DEF_MEM_AW
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/slave_port.sv
// -----------------------------------------------------------------------------
// slave_port: bit-serial memory slave.
//   A transaction starts when valid is seen in IDLE. ADDR_W address bits are
//   shifted in MSB first; for writes the last 8 of those cycles also carry the
//   data byte on data_rx. Writes commit in WRITE; reads pulse slave_valid for
//   one cycle and then shift the byte out on data_tx, MSB first.
//
// Optional feature: define SLAVE_WAIT_EN to insert WAIT_CYCLES cycles of
// READ_WAIT before the read acknowledge. Without it READ_WAIT is unreachable
// and no wait counter exists.
//
// Ports:
//   clock        in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   valid        in   transaction valid from master
//   write_en     in   1 = write, 0 = read (sampled in IDLE)
//   addr_rx      in   serial address, MSB first
//   data_rx      in   serial write data, MSB first
//   data_tx      out  serial read data, MSB first (0 outside READ_TX)
//   slave_valid  out  one-cycle pulse announcing read data
//   slave_ready  out  high only in IDLE
// -----------------------------------------------------------------------------
module slave_port
    import slave_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int MEM_AW      = DEF_MEM_AW,
    parameter int WAIT_CYCLES = 4
) (
    input  logic clock,
    input  logic rst_n,
    input  logic valid,
    input  logic write_en,
    input  logic addr_rx,
    input  logic data_rx,
    output logic data_tx,
    output logic slave_valid,
    output logic slave_ready
);

    localparam int CNT_W = cnt_width(ADDR_W);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_START = CNT_W'(ADDR_W - DATA_W);
    localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(DATA_W - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                is_write;
    // Only the low MEM_AW address bits are kept: MSB-first shifting pushes the
    // ignored upper bits out of the register on their own.
    logic [MEM_AW-1:0]   addr_q;
    logic [MEM_AW-1:0]   addr_next;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   rdata;
    logic [MEM_AW-1:0]   raddr;
    logic                mem_we;

`ifdef SLAVE_WAIT_EN
    localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_CYCLES - 1);
    logic [WCNT_W-1:0] wcnt;
`endif

    assign addr_next = {addr_q[MEM_AW-2:0], addr_rx};
    assign mem_we    = (state == ST_WRITE);

    // During RX the read address follows the bits as they arrive, so the
    // registered read of the final address completes by the READ_ACK cycle.
    assign raddr = (state == ST_RX) ? addr_next : addr_q;

    slave_bram #(.AW(MEM_AW)) u_bram (
        .clock (clock),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (data_q),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            is_write    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            shreg       <= '0;
            data_tx     <= 1'b0;
            slave_valid <= 1'b0;
            slave_ready <= 1'b1;
`ifdef SLAVE_WAIT_EN
            wcnt        <= '0;
`endif
        end else begin
            slave_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        is_write    <= write_en;
                        cnt         <= '0;
                        state       <= ST_RX;
                        slave_ready <= 1'b0;
                    end
                end

                ST_RX: begin
                    if (!valid) begin
                        // Abort: nothing committed, back to IDLE.
                        cnt         <= '0;
                        state       <= ST_IDLE;
                        slave_ready <= 1'b1;
                    end else begin
                        addr_q <= addr_next;
                        if (is_write && cnt >= DATA_START) begin
                            data_q <= {data_q[DATA_W-2:0], data_rx};
                        end
                        if (cnt == LAST_BIT) begin
                            cnt <= '0;
                            if (is_write) begin
                                state <= ST_WRITE;
                            end else begin
`ifdef SLAVE_WAIT_EN
                                wcnt  <= '0;
                                state <= ST_READ_WAIT;
`else
                                slave_valid <= 1'b1;
                                state       <= ST_READ_ACK;
`endif
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_WRITE: begin
                    state       <= ST_IDLE;
                    slave_ready <= 1'b1;
                end

`ifdef SLAVE_WAIT_EN
                ST_READ_WAIT: begin
                    if (wcnt == WAIT_LAST) begin
                        slave_valid <= 1'b1;
                        state       <= ST_READ_ACK;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
`endif

                ST_READ_ACK: begin
                    // First bit goes straight out; the rest queue in shreg.
                    data_tx <= rdata[DATA_W-1];
                    shreg   <= {rdata[DATA_W-2:0], 1'b0};
                    cnt     <= '0;
                    state   <= ST_READ_TX;
                end

                ST_READ_TX: begin
                    if (cnt == TX_LAST) begin
                        data_tx     <= 1'b0;
                        cnt         <= '0;
                        state       <= ST_IDLE;
                        slave_ready <= 1'b1;
                    end else begin
                        data_tx <= shreg[DATA_W-1];
                        shreg   <= {shreg[DATA_W-2:0], 1'b0};
                        cnt     <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    cnt         <= '0;
                    data_tx     <= 1'b0;
                    state       <= ST_IDLE;
                    slave_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/slave_port.md
SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, giving the serial address bits received per transaction.
REQ-002 The block SHALL have parameter MEM_AW, default 8, giving the memory address width, so depth is 2^MEM_AW bytes; MEM_AW <= ADDR_W.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 4, giving the read wait length; it is used only when SLAVE_WAIT_EN is defined.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port: clock  in  1  rising-edge clock.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: valid  in  1  transaction valid from the master.
REQ-008 Port: write_en  in  1  1=write, 0=read; sampled in IDLE when valid rises.
REQ-009 Port: addr_rx  in  1  serial address, MSB first.
REQ-010 Port: data_rx  in  1  serial write data, MSB first.
REQ-011 Port: data_tx  out  1  serial read data, MSB first.
REQ-012 Port: slave_valid  out  1  one-cycle pulse announcing read data.
REQ-013 Port: slave_ready  out  1  slave idle and able to accept a transaction.

Function
REQ-014 States SHALL be IDLE, RX, WRITE, READ_WAIT, READ_ACK and READ_TX.
REQ-015 IDLE: slave_ready=1. valid=1 SHALL latch write_en, clear the bit counter and go to RX.
REQ-016 RX: addr_rx SHALL be shifted into the address register every cycle for ADDR_W cycles; the first bit is sampled on the edge after the one that left IDLE.
REQ-017 RX write: data_rx SHALL be shifted into the data register on RX cycles ADDR_W-8 .. ADDR_W-1, so data MSB aligns with address bit index ADDR_W-8.
REQ-018 valid=0 during RX SHALL abort to IDLE next cycle with no memory write, no slave_valid and counters cleared.
REQ-019 After bit ADDR_W-1, a write SHALL go to WRITE; a read SHALL go to READ_WAIT if SLAVE_WAIT_EN is defined, else to READ_ACK.
REQ-020 WRITE SHALL write the data register to memory at address[MEM_AW-1:0] (upper address bits ignored), then go to IDLE after one cycle.
REQ-021 READ_ACK SHALL hold slave_valid=1 for exactly one cycle, load the shift register from memory, then go to READ_TX.
REQ-022 READ_TX SHALL drive data_tx with bits 7..0 for 8 consecutive cycles, one bit per cycle, then go to IDLE; data_tx SHALL be 0 outside READ_TX.
REQ-023 slave_ready SHALL be 0 in every state except IDLE.
REQ-024 During READ_WAIT/READ_ACK/READ_TX, valid is ignored.
REQ-025 Total write latency is ADDR_W+2 cycles from valid rising to slave_ready=1; read latency to the first data bit is ADDR_W+2 cycles (+WAIT_CYCLES with SLAVE_WAIT_EN).

Reset
REQ-026 rst_n=0 SHALL force IDLE, counters=0, data_tx=0, slave_valid=0 and slave_ready=1 immediately and asynchronously.
REQ-027 Reset mid-transaction SHALL abort it with no memory write; memory contents are not reset.

Configuration
REQ-028 With SLAVE_WAIT_EN defined, a read SHALL spend exactly WAIT_CYCLES cycles in READ_WAIT, with slave_valid=0, before READ_ACK.
REQ-029 Without SLAVE_WAIT_EN, READ_WAIT SHALL be unreachable, WAIT_CYCLES unused and no wait counter synthesized.

Structure
REQ-030 The state encoding, ADDR_W/MEM_AW defaults and data width 8 SHALL live in package slave_pkg.
REQ-031 Memory SHALL be a sub-module slave_bram (synchronous write, one-cycle registered read) instantiated once.

Verification
REQ-032 Write: addr 0x0A5, data 0x3C, then read 0x0A5 -> slave_valid pulse, data_tx serial 0,0,1,1,1,1,0,0.
REQ-033 Address aliasing: write 0x15A data 0xFF, read 0x05A -> reads 0xFF (MEM_AW=8).
REQ-034 valid drops after 5 address bits of a write to 0x010 data 0x77 -> IDLE next cycle, read 0x010 returns prior contents.
REQ-035 rst_n low during READ_TX bit 3 -> data_tx=0, slave_ready=1 at once; next transaction completes normally.
REQ-036 SLAVE_WAIT_EN, WAIT_CYCLES=4: read -> slave_valid exactly 4 cycles later than without the macro; slave_ready low throughout.
REQ-037 Back-to-back: valid high on the cycle slave_ready returns to 1 -> second transaction accepted with no lost bits.
